// File: rtl/mastage_pkg.sv
// mastage_pkg: shared definitions for the memory-access (MA) stage.
//   - Pipeline bus widths (EX->MA, MA->WB, MA->ID scoreboard).
//   - Bit offsets of every field on the EX->MA bus.
//   - Load size encodings.
//   - The packed layout of the MA->WB bundle.
//   - Small helpers for sign/zero extension.
package mastage_pkg;

  localparam int EX2MA_W = 74;
  localparam int MA2WB_W = 70;
  localparam int TOID_W  = 6;

  // EX->MA bus field offsets (LSB of each field)
  localparam int OFF_PC       = 0;
  localparam int OFF_ALU      = 32;
  localparam int OFF_DEST     = 64;
  localparam int OFF_GR_WE    = 69;
  localparam int OFF_LD_SIZE  = 70;
  localparam int OFF_LD_SIGN  = 72;
  localparam int OFF_RES_MEM  = 73;

  // Load size encodings; 2'b11 is decoded as a word
  localparam logic [1:0] LD_B = 2'b00;
  localparam logic [1:0] LD_H = 2'b01;
  localparam logic [1:0] LD_W = 2'b10;

  typedef struct packed {
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic [31:0] pc;
  } ma2wb_t;

  function automatic logic [31:0] ext8(input logic [7:0] v, input logic sgn);
    return {{24{sgn & v[7]}}, v};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
    return {{16{sgn & v[15]}}, v};
  endfunction

endpackage

// File: rtl/ma_load_align.sv
// ma_load_align: combinational load-data extraction.
//   raw        in  32  word returned by the data SRAM
//   a          in  2   low address bits of the access
//   ld_size    in  2   LD_B / LD_H / LD_W (11 behaves as word)
//   ld_sign    in  1   1 = sign-extend, 0 = zero-extend
//   load_data  out 32  aligned, extended load result
module ma_load_align
  import mastage_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  a,
  input  logic [1:0]  ld_size,
  input  logic        ld_sign,
  output logic [31:0] load_data
);

  logic [7:0]  w_byte [4];
  logic [15:0] w_half;

  // Byte lanes of the raw word, lane gi = raw[8gi+7:8gi]
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_byte[gi] = raw[8*gi +: 8];
    end
  endgenerate

  // a[0] is irrelevant for halfwords: misaligned accesses never reach MA
  assign w_half = a[1] ? raw[31:16] : raw[15:0];

  always_comb begin
    load_data = raw;
    case (ld_size)
      LD_B:    load_data = ext8(w_byte[a], ld_sign);
      LD_H:    load_data = ext16(w_half, ld_sign);
      default: load_data = raw;
    endcase
  end

endmodule

// File: rtl/mastage.sv
// mastage: memory-access stage between EX and WB.
//   clk, rst          pipeline clock, synchronous active-high reset
//   ex_validout  in   EX has an instruction to hand over
//   wb_allowin   in   WB can accept this cycle
//   ma_allowin   out  MA can accept from EX this cycle
//   ma_validout  out  MA holds a finished instruction for WB
//   ex_to_ma_bus in   74 b {res_from_mem, ld_sign, ld_size, gr_we, dest, alu_result, pc}
//   data_sram_rdata in 32 b SRAM data, valid only in the cycle after handoff
//   ma_to_wb_bus out  70 b {gr_we, dest, final_result, pc}
//   ma_to_id_bus out  6 b  {gr_we & valid, dest & valid} scoreboard entry
module mastage
  import mastage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_validout,
  input  logic               wb_allowin,
  output logic               ma_allowin,
  output logic               ma_validout,
  input  logic [EX2MA_W-1:0] ex_to_ma_bus,
  input  logic [31:0]        data_sram_rdata,
  output logic [MA2WB_W-1:0] ma_to_wb_bus,
  output logic [TOID_W-1:0]  ma_to_id_bus
);

  logic               r_valid;
  logic               r_first;
  logic [31:0]        r_rdata_hold;
  logic [EX2MA_W-1:0] r_ex_to_ma_bus;

  logic               w_readygo;
  logic               w_accept;
  logic               w_res_from_mem;
  logic               w_ld_sign;
  logic [1:0]         w_ld_size;
  logic               w_gr_we;
  logic [4:0]         w_dest;
  logic [31:0]        w_alu_result;
  logic [31:0]        w_pc;
  logic [31:0]        w_raw;
  logic [31:0]        w_load_data;
  ma2wb_t             w_to_wb;

  // MA never needs more than one cycle
  assign w_readygo   = 1'b1;
  assign ma_allowin  = ~r_valid | (w_readygo & wb_allowin);
  assign ma_validout = r_valid & w_readygo;
  assign w_accept    = ex_validout & ma_allowin;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid        <= 1'b0;
      r_first        <= 1'b0;
      r_rdata_hold   <= 32'd0;
      r_ex_to_ma_bus <= '0;
    end else begin
      if (ma_allowin) begin
        r_valid <= ex_validout;
      end
      if (w_accept) begin
        r_ex_to_ma_bus <= ex_to_ma_bus;
      end
      r_first <= w_accept;
      // SRAM data is only present in the first cycle; keep it for stalls
      if (r_valid & r_first) begin
        r_rdata_hold <= data_sram_rdata;
      end
    end
  end

  assign w_res_from_mem = r_ex_to_ma_bus[OFF_RES_MEM];
  assign w_ld_sign      = r_ex_to_ma_bus[OFF_LD_SIGN];
  assign w_ld_size      = r_ex_to_ma_bus[OFF_LD_SIZE +: 2];
  assign w_gr_we        = r_ex_to_ma_bus[OFF_GR_WE];
  assign w_dest         = r_ex_to_ma_bus[OFF_DEST +: 5];
  assign w_alu_result   = r_ex_to_ma_bus[OFF_ALU +: 32];
  assign w_pc           = r_ex_to_ma_bus[OFF_PC +: 32];

  assign w_raw = r_first ? data_sram_rdata : r_rdata_hold;

  ma_load_align u_align (
    .raw       (w_raw),
    .a         (w_alu_result[1:0]),
    .ld_size   (w_ld_size),
    .ld_sign   (w_ld_sign),
    .load_data (w_load_data)
  );

  // gr_we goes to WB ungated; WB qualifies it with its own valid
  assign w_to_wb.gr_we        = w_gr_we;
  assign w_to_wb.dest         = w_dest;
  assign w_to_wb.final_result = w_res_from_mem ? w_load_data : w_alu_result;
  assign w_to_wb.pc           = w_pc;
  assign ma_to_wb_bus         = w_to_wb;

  assign ma_to_id_bus = {w_gr_we & r_valid, w_dest & {5{r_valid}}};

endmodule

// File: doc/mastage.md
# mastage

Memory-access (MA) stage of the five-stage in-order pipeline, between the EX and WB stages. It latches the EX result bundle under the valid/allowin handshake and extracts, aligns and extends load data from the synchronous data SRAM. It holds that data across downstream stalls and sends the finished `{gr_we, dest, final_result, pc}` bundle to WB. It also drives the destination-register scoreboard bus to ID.

## Interface
Parameters: none. All widths are fixed by the pipeline bus definitions.

- `clk  in  1`  pipeline clock.
- `rst  in  1`  synchronous, active-high reset.
- `ex_validout  in  1`  EX holds a valid instruction ready to hand over.
- `wb_allowin  in  1`  WB can accept this cycle.
- `ma_allowin  out  1`  MA can accept from EX this cycle.
- `ma_validout  out  1`  MA holds a valid, finished instruction for WB.
- `ex_to_ma_bus  in  74`  fields:
  - `res_from_mem` [73]
  - `ld_sign` [72]
  - `ld_size` [71:70] (00 byte, 01 half, 10 word)
  - `gr_we` [69]
  - `dest` [68:64]
  - `alu_result` [63:32] (also the load address)
  - `pc` [31:0]
- `data_sram_rdata  in  32`  SRAM read data. EX issues the request in its handoff cycle, so the data is valid only in the first cycle after the EX→MA transfer.
- `ma_to_wb_bus  out  70`  fields: `gr_we` [69], `dest` [68:64], `final_result` [63:32], `pc` [31:0].
- `ma_to_id_bus  out  6`  `{gr_we & valid, dest & {5{valid}}}`.

## Operation
- State registers:
  - `valid`
  - `ex_to_ma_bus_r` (74 b)
  - `first`: the current cycle is the first cycle after accept
  - `rdata_hold` (32 b)
- Accept: on `ex_validout & ma_allowin`, latch the bus, set `first` to 1 and set `valid` to 1.
- When `ma_allowin` is high and `ex_validout` is low, `valid` becomes 0.
- `readygo` = 1: the stage always finishes in one cycle.
- `ma_allowin = ~valid | (readygo & wb_allowin)`.
- `ma_validout = valid & readygo`.
- Load-word source: `raw = first ? data_sram_rdata : rdata_hold`.
- When `valid & first`, capture `data_sram_rdata` into `rdata_hold`. `first` clears on every cycle without an accept.
- Alignment uses `a = alu_result[1:0]`:
  - Byte: `raw[8a+7:8a]`.
  - Half: `a[1] ? raw[31:16] : raw[15:0]`.
  - Word: `raw`.
  - `ld_sign` = 1 sign-extends to 32 b; `ld_sign` = 0 zero-extends.
  - `ld_size` = 11 is treated as word.
  - `a[0]` is ignored for halfwords. EX has already rejected misaligned accesses.
- `final_result = res_from_mem ? load_data : alu_result`.
- `gr_we`, `dest` and `pc` pass through unchanged.
- MA does not gate `gr_we` into WB; WB masks it with its own valid.

## Timing
- Reset values:
  - `valid` = 0, `first` = 0, `rdata_hold` = 0, `ex_to_ma_bus_r` = 0.
  - As a result: `ma_validout` = 0, `ma_allowin` = 1, `ma_to_wb_bus` = 0, `ma_to_id_bus` = 0.
- Latency: one cycle from EX handoff to `ma_validout`. With `wb_allowin` high, back-to-back instructions flow at 1 per cycle.
- Stall: while `valid & ~wb_allowin`:
  - The bus register, `valid` and `rdata_hold` stay frozen.
  - `first` is 0 after the first stalled cycle, so `final_result` stays stable even if `data_sram_rdata` changes.
- Simultaneous handoff: when WB takes the current instruction and EX delivers a new one in the same cycle, the new one is latched and `first` is set to 1. `rdata_hold` from the previous load is overwritten on the next cycle.
- Reset mid-operation overrides everything. The in-flight instruction is dropped and its `gr_we` is never presented.

## Structure
- Shared package:
  - Bus widths (`EX2MA_W` = 74, `MA2WB_W` = 70, `TOID_W` = 6).
  - Field bit offsets.
  - `ld_size` encodings (`LD_B`, `LD_H`, `LD_W`).
- Sub-module `ma_load_align`: purely combinational. Inputs `raw`, `a`, `ld_size`, `ld_sign`; output 32 b `load_data`.
- The top level holds the handshake, the registers and the result mux.

## Test plan
- `ld.w`, addr `0x1000`, rdata `0xDEADBEEF`, `wb_allowin` = 1 → next cycle `ma_validout` = 1 and `final_result` = `0xDEADBEEF`.
- `ld.b` signed, addr `0x1003`, rdata `0x80112233` → `0xFFFFFF80`. Same access with `ld_sign` = 0 → `0x00000080`.
- `ld.hu`, addr `0x1002`, rdata `0xBEEF1234` → `0x0000BEEF`. `ld.h` (signed) at addr `0x1000` → `0x00001234`.
- `ld.w` with `wb_allowin` = 0 for 3 cycles while rdata changes `0xAAAA5555` → `0x12345678` → `0x0` → `final_result` stays `0xAAAA5555` throughout, `ma_allowin` = 0, EX stays blocked.
- Back-to-back ALU op (`alu_result` `0x7`, dest 3) then `ld.b` → results on consecutive cycles and `ma_to_id_bus` = `{1, 3}` then `{1, dest2}`.
- Assert `rst` while a load is valid and stalled → next cycle `ma_validout` = 0, `ma_allowin` = 1, `ma_to_id_bus` = 0.
